uart_rx_controller: RTL

//  Sequences UART frame reception on onebit_data_in: start-bit detection, 16x oversampled
//  mid-bit sampling, 8-bit LSB-first deserialisation, stop-bit check.

---
 rtl/uart_rx_controller_pkg.sv | 16 +
 rtl/uart_rx_controller_baud_tick.sv | 29 ++
 rtl/uart_rx_controller.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_controller_pkg.sv
// Shared UART definitions: receiver state encodings and frame constants.
// Intended for reuse by the transmit side as well.
package uart_rx_controller_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_controller_baud_tick.sv
// Oversample enable generator: one-clk tick every DIV clocks.
// The count restarts on clr so sampling phase follows the start edge.
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic btn0,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge btn0) begin
        if (!btn0) begin
            r_cnt <= '0;
        end else if (clr || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_controller.sv
// UART receiver: 16x oversampled framing, LSB-first deserialisation,
// valid/ready byte handshake with overrun tracking and a last-byte LED mirror.
module uart_rx_controller
    import uart_rx_controller_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic       clk,
    input  logic       btn0,
    input  logic       rx_en,
    input  logic       onebit_data_in,
    input  logic       data_ready,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [7:0] led
);

    localparam int DIV_RAW = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TC_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TC_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]    BC_LAST = 3'(UART_DATA_BITS - 1);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    logic [TW-1:0]   r_tick_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shreg;
    logic [7:0]      r_data_out;
    logic            r_data_valid;
    logic            r_frame_err;
    logic            r_overrun;
    logic [7:0]      r_led;

    logic            w_rx_s;
    logic            w_tick;
    logic            w_clr;
    logic            w_deliver;
    logic            w_ferr;
    rx_state_t       w_state_nxt;
    logic [TW-1:0]   w_tick_nxt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      w_shreg_nxt;

    // Line is asynchronous to clk; idle-high reset avoids a false start.
    always_ff @(posedge clk or negedge btn0) begin
        if (!btn0) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= onebit_data_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .btn0 (btn0),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge btn0) begin
        if (!btn0) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shreg    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shreg    <= w_shreg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shreg_nxt = r_shreg;
        w_clr       = 1'b0;
        w_deliver   = 1'b0;
        w_ferr      = 1'b0;
        if (!rx_en) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                        w_clr       = 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TC_MID) begin
                            if (w_rx_s) begin
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_state_nxt = S_DATA;
                                w_tick_nxt  = '0;
                                w_bit_nxt   = '0;
                            end
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TC_LAST) begin
                            w_shreg_nxt = {w_rx_s, r_shreg[7:1]};
                            w_tick_nxt  = '0;
                            if (r_bit_cnt == BC_LAST) begin
                                w_state_nxt = S_STOP;
                            end else begin
                                w_bit_nxt = r_bit_cnt + 1'b1;
                            end
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (r_tick_cnt == TC_LAST) begin
                            w_tick_nxt = '0;
                            if (w_rx_s) begin
                                w_deliver   = 1'b1;
                                w_state_nxt = S_IDLE;
                            end else begin
                                w_ferr      = 1'b1;
                                w_state_nxt = S_BREAK;
                            end
                        end else begin
                            w_tick_nxt = r_tick_cnt + 1'b1;
                        end
                    end
                end
                S_BREAK: begin
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // A delivery coinciding with a handshake swaps the pending byte.
    always_ff @(posedge clk or negedge btn0) begin
        if (!btn0) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
            r_led        <= '0;
        end else begin
            r_frame_err <= w_ferr;
            if (w_deliver) begin
                if (!r_data_valid) begin
                    r_data_out   <= r_shreg;
                    r_data_valid <= 1'b1;
                end else if (data_ready) begin
                    r_led      <= r_data_out;
                    r_data_out <= r_shreg;
                    r_overrun  <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_data_valid && data_ready) begin
                r_data_valid <= 1'b0;
                r_led        <= r_data_out;
                r_overrun    <= 1'b0;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign led        = r_led;
    assign busy       = (r_state != S_IDLE);

endmodule
